// File: rtl/clk_gen_pkg.sv
// Shared types and default divisors for the clock divider bank.
package clk_gen_pkg;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_STOP = 2'd2
  } ch_state_e;

  // Half-period divisors from the 50 MHz board clock.
  localparam logic [15:0] PX_DIV_DEF  = 16'd1;      // 25 MHz pixel clock
  localparam logic [15:0] I2C_DIV_DEF = 16'd10000;  // 2.5 kHz I2C clock

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: down-counter, run/stop state, shadowed divisor and
// registered clk_out/tick.
module clk_div_chan
  import clk_gen_pkg::*;
#(
  parameter int unsigned      DIV_W       = 16,
  parameter logic [DIV_W-1:0] DIV_RST_VAL = {{(DIV_W-1){1'b0}}, 1'b1}
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             ch_en,
  input  logic             sync_restart,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);

  ch_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pvld_q, pvld_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic             term;
  logic [DIV_W-1:0] reload_div;
  logic             wr_direct;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pvld_d     = pvld_q;
    clk_d      = clk_q;
    term       = (cnt_q == '0);
    reload_div = pvld_q ? pend_q : act_q;
    wr_direct  = 1'b0;

    if (sync_restart) begin
      if (pvld_q) begin
        act_d  = pend_q;
        pvld_d = 1'b0;
      end
      clk_d = 1'b0;
      if (ch_en && reload_div != '0) begin
        state_d = CH_RUN;
        cnt_d   = reload_div - DIV_W'(1);
      end else begin
        state_d = CH_IDLE;
        cnt_d   = '0;
      end
      wr_direct = (state_d == CH_IDLE);
    end else begin
      wr_direct = (state_q == CH_IDLE);
      case (state_q)
        CH_IDLE: begin
          if (ch_en && act_q != '0) begin
            state_d = CH_RUN;
            cnt_d   = act_q - DIV_W'(1);
          end
        end
        CH_RUN, CH_STOP: begin
          if (term) begin
            if (pvld_q) begin
              act_d  = pend_q;
              pvld_d = 1'b0;
            end
            cnt_d = reload_div - DIV_W'(1);
            clk_d = ~clk_q;
          end else begin
            cnt_d = cnt_q - DIV_W'(1);
          end
          // Disabling during the low phase stops at once; during the high
          // phase the high half completes before the channel parks.
          if (ch_en) begin
            state_d = CH_RUN;
          end else if (!clk_q || term) begin
            state_d = CH_IDLE;
            clk_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = CH_STOP;
          end
        end
        default: begin
          state_d = CH_IDLE;
          clk_d   = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end

    // Written after the terminal handling so a write in a reload cycle
    // still lands in the shadow for the next period.
    if (wr_en) begin
      if (wr_direct) begin
        act_d = wr_div;
      end else begin
        pend_d = wr_div;
        pvld_d = 1'b1;
      end
    end

    tick_d = clk_d & ~clk_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      act_q   <= DIV_RST_VAL;
      pend_q  <= '0;
      pvld_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pvld_q  <= pvld_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign running = (state_q != CH_IDLE);

endmodule

// File: rtl/clk_div_bank.sv
// Bank of programmable clock dividers sharing one config port; decodes
// divisor writes and fans them out to per-channel dividers.
module clk_div_bank
  import clk_gen_pkg::*;
#(
  parameter int unsigned               N_CH    = 2,
  parameter int unsigned               DIV_W   = 16,
  parameter logic [N_CH*DIV_W-1:0]     DIV_RST = {I2C_DIV_DEF, PX_DIV_DEF},
  localparam int unsigned              CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             sync_restart,
  input  logic             cfg_wr,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  running
);

  localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);

  logic            cfg_ok;
  logic            cfg_ack_q, cfg_ack_d;
  logic            cfg_err_q, cfg_err_d;
  logic [N_CH-1:0] ch_wr;

  always_comb begin
    cfg_ok    = cfg_wr && ({1'b0, cfg_ch} < N_CH_L) && (cfg_div != '0);
    cfg_ack_d = cfg_ok;
    cfg_err_d = cfg_wr && !cfg_ok;
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      cfg_ack_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_ack_q <= cfg_ack_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_ack = cfg_ack_q;
  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign ch_wr[g] = cfg_ok && (cfg_ch == CH_W'(g));

    clk_div_chan #(
      .DIV_W       (DIV_W),
      .DIV_RST_VAL (DIV_RST[g*DIV_W +: DIV_W])
    ) u_chan (
      .CLK          (CLK),
      .RST_n        (RST_n),
      .ch_en        (ch_en[g]),
      .sync_restart (sync_restart),
      .wr_en        (ch_wr[g]),
      .wr_div       (cfg_div),
      .clk_out      (clk_out[g]),
      .tick         (tick[g]),
      .running      (running[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank with three channels so that an
// out-of-range channel select is expressible.
module tb_clk_div_bank;

  localparam int N_CH  = 3;
  localparam int DIV_W = 16;
  localparam int CH_W  = 2;

  logic             CLK = 1'b0;
  logic             RST_n;
  logic [N_CH-1:0]  ch_en;
  logic             sync_restart;
  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ack, cfg_err;
  logic [N_CH-1:0]  clk_out, tick, running;

  clk_div_bank #(
    .N_CH    (N_CH),
    .DIV_W   (DIV_W),
    .DIV_RST ({16'd6, 16'd10000, 16'd1})
  ) dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .ch_en        (ch_en),
    .sync_restart (sync_restart),
    .cfg_wr       (cfg_wr),
    .cfg_ch       (cfg_ch),
    .cfg_div      (cfg_div),
    .cfg_ack      (cfg_ack),
    .cfg_err      (cfg_err),
    .clk_out      (clk_out),
    .tick         (tick),
    .running      (running)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {logic ack; logic err;} cfg_exp_t;
  typedef struct {
    logic [CH_W-1:0]  ch;
    logic [DIV_W-1:0] div;
    logic             ack;
    logic             err;
  } cfg_vec_t;

  cfg_exp_t exp_q[$];
  cfg_vec_t vecs[7];
  int n_vec = 0, n_err = 0, cyc = 0, ack_cnt = 0;
  logic exp_ack_nx = 1'b0, exp_err_nx = 1'b0;
  logic [N_CH-1:0] prev_clk = '0;
  int rise0[$], fall0[$], rise1[$], fall1[$];

  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      if (n_err <= 20) $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // One clock: queue the expected config response for the inputs now driven,
  // then sample after the edge and retire it.
  task automatic step();
    cfg_exp_t e, got;
    e.ack = exp_ack_nx;
    e.err = exp_err_nx;
    exp_q.push_back(e);
    @(negedge CLK);
    cyc++;
    got = exp_q.pop_front();
    chk("cfg_ack", cfg_ack, got.ack);
    chk("cfg_err", cfg_err, got.err);
    chk("tick_vs_rise", tick, clk_out & ~prev_clk);
    if (cfg_ack) ack_cnt++;
    if (clk_out[0] && !prev_clk[0]) rise0.push_back(cyc);
    if (!clk_out[0] && prev_clk[0]) fall0.push_back(cyc);
    if (clk_out[1] && !prev_clk[1]) rise1.push_back(cyc);
    if (!clk_out[1] && prev_clk[1]) fall1.push_back(cyc);
    prev_clk = clk_out;
  endtask

  task automatic cfg_write(input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] div,
                           input logic ack, input logic err);
    cfg_wr = 1'b1; cfg_ch = ch; cfg_div = div;
    exp_ack_nx = ack; exp_err_nx = err;
    step();
    cfg_wr = 1'b0; exp_ack_nx = 1'b0; exp_err_nx = 1'b0;
  endtask

  task automatic clear_edges();
    rise0.delete(); fall0.delete(); rise1.delete(); fall1.delete();
  endtask

  initial begin
    int t0, coinc, first_coinc;

    vecs[0] = '{2'd0, 16'd3, 1'b1, 1'b0};
    vecs[1] = '{2'd1, 16'd5, 1'b1, 1'b0};
    vecs[2] = '{2'd3, 16'd7, 1'b0, 1'b1};
    vecs[3] = '{2'd0, 16'd0, 1'b0, 1'b1};
    vecs[4] = '{2'd1, 16'd0, 1'b0, 1'b1};
    vecs[5] = '{2'd2, 16'd0, 1'b0, 1'b1};
    vecs[6] = '{2'd2, 16'd6, 1'b1, 1'b0};

    RST_n = 1'b0; ch_en = '0; sync_restart = 1'b0;
    cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0;
    repeat (3) step();
    chk("rst_clk_out", clk_out, 0);
    chk("rst_running", running, 0);
    RST_n = 1'b1;
    repeat (2) step();
    chk("idle_after_rst", running, 0);

    // Reset divisors: ch0 CLK/2, ch1 half-period 10000.
    clear_edges();
    t0 = cyc; ch_en = 3'b011;
    repeat (30002) step();
    chk("t1_running", running, 3'b011);
    chk("t1_ch0_rise0", rise0[0] - t0, 2);
    chk("t1_ch0_rise1", rise0[1] - t0, 4);
    chk("t1_ch0_nrise", rise0.size(), 15001);
    chk("t1_ch1_rise0", rise1[0] - t0, 10001);
    chk("t1_ch1_fall0", fall1[0] - t0, 20001);
    chk("t1_ch1_rise1", rise1[1] - t0, 30001);

    // Abrupt stop of everything, then config writes to idle channels.
    ch_en = '0; sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    chk("restart_stop_running", running, 0);
    chk("restart_stop_clk", clk_out, 0);
    foreach (vecs[i]) cfg_write(vecs[i].ch, vecs[i].div, vecs[i].ack, vecs[i].err);

    // Phase alignment with DIV 3 and 5; rejected writes must not have landed.
    ch_en = 3'b011;
    repeat (7) step();
    clear_edges();
    t0 = cyc; sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    chk("sync_clk_low", clk_out[1:0], 0);
    chk("sync_running", running, 3'b011);
    repeat (63) step();
    chk("sync_ch0_rise0", rise0[0] - t0, 4);
    chk("sync_ch0_rise1", rise0[1] - t0, 10);
    chk("sync_ch1_rise0", rise1[0] - t0, 6);
    chk("sync_ch1_rise1", rise1[1] - t0, 16);
    coinc = 0; first_coinc = -1;
    foreach (rise0[i]) foreach (rise1[j]) if (rise0[i] == rise1[j]) begin
      coinc++;
      if (first_coinc < 0) first_coinc = rise0[i] - t0;
    end
    chk("sync_coincident_cnt", coinc, 2);
    chk("sync_coincident_first", first_coinc, 16);

    // Shadowed reload: 4 -> 2 written in the middle of a high half.
    ch_en = '0; sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    cfg_write(2'd0, 16'd4, 1'b1, 1'b0);
    clear_edges(); ack_cnt = 0;
    t0 = cyc; ch_en = 3'b001;
    while (cyc < t0 + 6) step();
    cfg_write(2'd0, 16'd2, 1'b1, 1'b0);
    while (cyc < t0 + 16) step();
    chk("reload_rise0", rise0[0] - t0, 5);
    chk("reload_fall0", fall0[0] - t0, 9);
    chk("reload_rise1", rise0[1] - t0, 11);
    chk("reload_fall1", fall0[1] - t0, 13);
    chk("reload_rise2", rise0[2] - t0, 15);
    chk("reload_ack_cnt", ack_cnt, 1);

    // Disable ch1 during its high phase: full high half, no runt.
    ch_en = '0; sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    clear_edges();
    t0 = cyc; ch_en = 3'b010;
    while (cyc < t0 + 8) step();
    chk("stop_pre_high", clk_out[1], 1);
    ch_en = '0;
    step(); step();
    chk("stop_running_mid", running[1], 1);
    chk("stop_clk_mid", clk_out[1], 1);
    step();
    chk("stop_running_end", running[1], 0);
    chk("stop_clk_end", clk_out[1], 0);
    repeat (20) step();
    chk("stop_fall_time", fall1[0] - t0, 11);
    chk("stop_nrise", rise1.size(), 1);
    chk("stop_nfall", fall1.size(), 1);

    // Reset in the middle of a high phase.
    t0 = cyc; ch_en = 3'b011;
    while (cyc < t0 + 8) step();
    chk("rst_pre_high", clk_out[1], 1);
    RST_n = 1'b0;
    step();
    chk("rst_mid_clk", clk_out, 0);
    chk("rst_mid_running", running, 0);
    ch_en = '0; RST_n = 1'b1;
    repeat (5) step();
    chk("rst_rel_running", running, 0);
    chk("rst_rel_clk", clk_out, 0);
    clear_edges();
    t0 = cyc; ch_en = 3'b001;
    repeat (5) step();
    chk("rst_div_restored", rise0[0] - t0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
